// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a byte FIFO behind a single bus status/data register.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1 framing, parity_err in dout[11]).
module uart_rx #(
  parameter int CLKS_PER_BIT = 174,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        valid,
  input  logic        wr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic [1:0]    r_sync;
  logic          w_rx_s;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_push;
  logic          r_ferr_set;
  logic          r_perr_set;
`ifdef UART_RX_PARITY_EN
  logic          r_par_bad;
`endif

  logic          r_valid_q;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_parity_err;
  logic [31:0]   r_dout;
  logic          r_irq;

  logic          w_rd_start;
  logic          w_wr_start;
  logic          w_flush;
  logic          w_clear;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_do_push;
  logic          w_ovr_set;
  logic [7:0]    w_head;
  logic [8:0]    w_cnt_ext;
  logic [4:0]    w_cnt_sat;
  logic          w_unused_din;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], rxd};
  end

  // Frame FSM; push/error pulses are registered and act on the FIFO one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_push     <= 1'b0;
      r_ferr_set <= 1'b0;
      r_perr_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
`endif
    end else begin
      r_push     <= 1'b0;
      r_ferr_set <= 1'b0;
      r_perr_set <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (r_bit == 3'd7) r_state <= S_PARITY;
`else
            if (r_bit == 3'd7) r_state <= S_STOP;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == C_LAST) begin
            r_cnt     <= '0;
            r_par_bad <= ^{r_shift, w_rx_s};
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == C_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
              r_perr_set <= r_par_bad;
              r_push     <= ~r_par_bad;
`else
              r_push     <= 1'b1;
`endif
              r_state <= S_IDLE;
            end else begin
              r_ferr_set <= 1'b1;
              r_state    <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rd_start   = valid & ~wr & ~r_valid_q;
  assign w_wr_start   = valid &  wr & ~r_valid_q;
  assign w_flush      = w_wr_start & din[1];
  assign w_clear      = w_wr_start & din[0];
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == C_DEPTH);
  assign w_pop        = w_rd_start & ~w_empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is not an overrun then.
  assign w_do_push    = r_push & ~w_flush & (~w_full | w_pop);
  assign w_ovr_set    = r_push & ~w_flush & w_full & ~w_pop;
  assign w_head       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign w_cnt_ext    = 9'(r_count);
  assign w_cnt_sat    = (w_cnt_ext > 9'd31) ? 5'd31 : w_cnt_ext[4:0];
  assign w_unused_din = ^din[31:2];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q    <= 1'b0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
      r_dout       <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_valid_q <= valid;
      r_irq     <= ~w_empty;
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        case ({w_do_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      r_frame_err  <= (r_frame_err  & ~w_clear) | r_ferr_set;
      r_overrun    <= (r_overrun    & ~w_clear) | w_ovr_set;
      r_parity_err <= (r_parity_err & ~w_clear) | r_perr_set;
      if (w_rd_start)
        r_dout <= {11'b0, w_cnt_sat, 4'b0, r_parity_err, r_overrun, r_frame_err,
                   ~w_empty, w_head};
    end
  end

  assign dout = r_dout;
  assign irq  = r_irq;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a queue/flag model predicts every read word; dout is tracked each cycle.
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        valid = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad = 0;
  logic        chk_on = 1'b0;
  logic [31:0] exp_dout = '0;
  logic        irq_a, irq_b;

  logic [7:0] mq[$];
  logic m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .valid(valid), .wr(wr),
    .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (dout !== exp_dout) begin
        bad++;
        $display("FAIL dout_track t=%0t act=%h exp=%h", $time, dout, exp_dout);
      end
    end
  end

  function automatic logic [31:0] model_dout();
    int n = mq.size();
    logic [4:0] c = (n > 31) ? 5'd31 : 5'(n);
    logic [7:0] h = (n != 0) ? mq[0] : 8'h00;
    return {11'b0, c, 4'b0, m_pe, m_ov, m_fe, (n != 0), h};
  endfunction

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame; a zero stop bit leaves rxd low for the caller to release.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ bad_par);
`endif
    drive_bit(stop);
    if (!stop)             m_fe = 1'b1;
    else if (bad_par)      m_pe = 1'b1;
    else if (mq.size() == DEPTH) m_ov = 1'b1;
    else                   mq.push_back(b);
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_read(input int hold, output logic [31:0] d);
    logic [31:0] e;
    @(negedge clk);
    e = model_dout();
    if (mq.size() != 0) mq.delete(0);
    valid = 1'b1;
    wr = 1'b0;
    @(posedge clk); #1;
    exp_dout = e;
    d = dout;
    irq_a = irq;
    @(posedge clk); #1;
    irq_b = irq;
    repeat (hold - 2) @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1;
    wr = 1'b1;
    din = d;
    if (d[0]) begin m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0; end
    if (d[1]) mq.delete();
    @(negedge clk);
    valid = 1'b0;
    wr = 1'b0;
    din = '0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_irq_up", {31'b0, irq}, 32'h1);
    bus_read(2, d);
    check("a5_dout", d, 32'h0001_01A5);
    check("a5_irq_at_pop", {31'b0, irq_a}, 32'h1);
    check("a5_irq_after_pop", {31'b0, irq_b}, 32'h0);

    for (int i = 0; i < 16; i++) send_frame(8'(8'h11 + i), 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      bus_read(2, d);
      if (i == 0)  check("ovf_first", d, 32'h0010_0511);
      if (i < 16)  check("ovf_byte", {24'b0, d[7:0]}, 32'(8'h11 + i));
      if (i == 16) check("ovf_last_ne", {31'b0, d[8]}, 32'h0);
    end
    bus_write(32'h1);
    bus_read(2, d);
    check("ovf_cleared", d, 32'h0);

    @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_irq", {31'b0, irq}, 32'h0);
    bus_read(2, d);
    check("glitch_dout", d, 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0);
    bus_read(2, d);
    check("post_glitch", d, 32'h0001_015A);

    send_frame(8'hFF, 1'b0, 1'b0);
    repeat (100 * CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    bus_read(2, d);
    check("ferr_3c", d, 32'h0001_033C);
    bus_read(2, d);
    check("ferr_empty", d, 32'h0000_0200);
    bus_write(32'h1);

    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    bus_read(10, d);
    check("long_rd1", d, 32'h0002_0181);
    bus_read(2, d);
    check("long_rd2", d, 32'h0001_0142);

    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    bus_write(32'h2);
    repeat (3) @(negedge clk);
    check("flush_irq", {31'b0, irq}, 32'h0);
    bus_read(2, d);
    check("flush_dout", d, 32'h0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    bus_read(2, d);
    check("par_good", d, 32'h0001_0907);
    bus_read(2, d);
    check("par_bad", d, 32'h0000_0800);
    bus_write(32'h1);
`endif

    repeat (5) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
